// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift register; MSB_FIRST picks which end feeds the serial tap.
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sr_q;

  // Load wins over shift so a back-to-back accept replaces the drained word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      if (MSB_FIRST) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      else           sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign dout = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// Serializer: FSM, bit counter, optional parity and ready/valid handshake.
// Optional even parity bit is enabled by defining PISO_TX_PARITY_EN.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int unsigned CW = cnt_width(WIDTH);
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_c;
  logic            accept_c;
  logic            sr_bit;
  logic            bit_c;

  assign last_c   = (state_q == SHIFT) && (cnt_q == CW'(FLEN - 1));
  assign in_ready = !rst && ((state_q == IDLE) || last_c);
  assign accept_c = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_c) begin
          cnt_d   = '0;
          state_d = accept_c ? SHIFT : IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk  (clk),
    .rst  (rst),
    .load (accept_c),
    .shift(state_q == SHIFT),
    .din  (in),
    .dout (sr_bit)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  // Parity is latched with the word so later changes to in cannot affect it.
  always_ff @(posedge clk) begin
    if (rst)           par_q <= 1'b0;
    else if (accept_c) par_q <= ^in;
  end

  assign bit_c = (cnt_q == CW'(WIDTH)) ? par_q : sr_bit;
`else
  assign bit_c = sr_bit;
`endif

  assign out_valid = (state_q == SHIFT);
  assign out_last  = last_c;
  assign out       = (state_q == SHIFT) ? bit_c : 1'b0;

endmodule
